// File: rtl/bp_pkg.sv
// Shared types for the branch target buffer: counter encoding, init FSM states
// and the 2-bit saturating counter next-state rule.
// Combinational helpers only, no state.
package bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  // Saturating step: taken moves toward STRONG_T, not-taken toward STRONG_NT.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != STRONG_T) nxt = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != STRONG_NT) nxt = ctr_t'(ctr - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Purpose: next-state of one 2-bit saturating direction counter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, used only when an update is accepted.
module bp_sat_ctr
  import bp_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  // Saturating increment/decrement of the stored counter.
  always_comb begin
    ctr_next = sat_update(ctr, taken);
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Purpose: direct-mapped BTB with 2-bit counters; predicts next fetch PC in IF,
//          trained by the resolved-branch port. Optional stats: define BP_STATS_EN.
// Latency: lookup is combinational (0 cycles); training is visible the next cycle.
// Backpressure: none; updates arriving while Ready=0 (init sweep) are dropped.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int         PC_WIDTH   = 32,
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CTR_ALLOC  = 2'd2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] NextPC,
  output logic                PredTaken,
  output logic                Ready,
  input  logic                UpdValid,
  input  logic [PC_WIDTH-1:0] UpdPC,
  input  logic                UpdTaken,
  input  logic [PC_WIDTH-1:0] UpdTarget
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         StatUpdates,
  output logic [31:0]         StatMispred
`endif
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = PC_WIDTH - INDEX_BITS - 2;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;
  localparam logic [INDEX_BITS-1:0] IDX_ONE  = INDEX_BITS'(1);
  localparam ctr_t ALLOC_CTR = ctr_t'(CTR_ALLOC);

  // Table storage; only valid is swept, the payload is gated by valid.
  logic                valid_q  [DEPTH];
  logic [TAG_W-1:0]    tag_q    [DEPTH];
  logic [PC_WIDTH-1:0] target_q [DEPTH];
  ctr_t                ctr_q    [DEPTH];

  bp_state_t           state_q;
  logic [INDEX_BITS-1:0] ptr_q;
  logic                ready_q;

  // Lookup side
  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;

  // Update side
  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic                  up_en;
  ctr_t                  up_ctr_next;

  // Word-offset bits carry no information for prediction.
  logic unused_lsb;
  assign unused_lsb = ^{PC[1:0], UpdPC[1:0]};

  assign lk_idx = PC[INDEX_BITS+1:2];
  assign lk_tag = PC[PC_WIDTH-1:INDEX_BITS+2];
  assign up_idx = UpdPC[INDEX_BITS+1:2];
  assign up_tag = UpdPC[PC_WIDTH-1:INDEX_BITS+2];

  // Reset also masks the lookup so a registered Ready cannot leak a hit during Rst.
  assign lk_hit = ready_q & ~Rst & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
  assign up_en  = UpdValid & ready_q & ~Rst;

  // Predict: strong/weak taken hit redirects, everything else falls through to PC+4.
  always_comb begin
    NextPC    = PC + PC_WIDTH'(4);
    PredTaken = 1'b0;
    if (lk_hit && ctr_q[lk_idx][1]) begin
      NextPC    = target_q[lk_idx];
      PredTaken = 1'b1;
    end
  end

  assign Ready = ready_q;

  bp_sat_ctr u_sat_ctr (
    .ctr      (ctr_q[up_idx]),
    .taken    (UpdTaken),
    .ctr_next (up_ctr_next)
  );

  // Init FSM: sweep pointer walks the table once after every reset, then enables the BTB.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          ptr_q <= ptr_q + IDX_ONE;
          if (ptr_q == LAST_IDX) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= INIT;
          ptr_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Valid bits: cleared one per cycle by the sweep, set by a taken-miss allocation.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state_q == INIT) begin
        valid_q[ptr_q] <= 1'b0;
      end else if (up_en && !up_hit && UpdTaken) begin
        valid_q[up_idx] <= 1'b1;
      end
    end
  end

  // Payload write: train counter/target on hit, overwrite whole entry on taken miss.
  always_ff @(posedge Clk) begin
    if (up_en) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_next;
        if (UpdTaken) target_q[up_idx] <= UpdTarget;
      end else if (UpdTaken) begin
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= UpdTarget;
        ctr_q[up_idx]    <= ALLOC_CTR;
      end
    end
  end

`ifdef BP_STATS_EN
  logic up_pred;
  assign up_pred = up_hit & ctr_q[up_idx][1];

  // Accepted-update and misprediction counters; free-running, wrap at 2**32.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StatUpdates <= '0;
      StatMispred <= '0;
    end else if (up_en) begin
      StatUpdates <= StatUpdates + 32'd1;
      if (up_pred != UpdTaken) StatMispred <= StatMispred + 32'd1;
    end
  end
`endif

endmodule
